// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared opcodes, table polarity and FSM states for the TS PID table controller
package ts_pkg;

  localparam int PID_W = 13;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_PASS_PID   = 3'd1;
  localparam logic [2:0] OP_DROP_PID   = 3'd2;
  localparam logic [2:0] OP_PASS_RANGE = 3'd3;
  localparam logic [2:0] OP_DROP_RANGE = 3'd4;
  localparam logic [2:0] OP_PASS_ALL   = 3'd5;
  localparam logic [2:0] OP_DROP_ALL   = 3'd6;
  localparam logic [2:0] OP_RSVD       = 3'd7;

  localparam logic TBL_PASS = 1'b0;
  localparam logic TBL_DROP = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT_SWEEP = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_FLUSH      = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/ts_pid_table_ctrl_if.sv
// rtl/ts_pid_table_ctrl_if.sv - host command bus and filter table port of the PID table controller
interface ts_pid_table_ctrl_if
  import ts_pkg::*;
#(
  parameter int PID_W = ts_pkg::PID_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [PID_W-1:0] cmd_pid_lo;
  logic [PID_W-1:0] cmd_pid_hi;
  logic             cmd_flush;
  logic [PID_W-1:0] table_wr_address;
  logic             table_data;
  logic             table_wren;
  logic             filter_aclr;
  logic             busy;
  logic             cmd_done;
  logic             cmd_err;
  logic [PID_W:0]   write_count;

  modport master (
    output cmd_valid, cmd_op, cmd_pid_lo, cmd_pid_hi, cmd_flush,
    input  cmd_ready, table_wr_address, table_data, table_wren,
    input  filter_aclr, busy, cmd_done, cmd_err, write_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pid_lo, cmd_pid_hi, cmd_flush,
    output cmd_ready, table_wr_address, table_data, table_wren,
    output filter_aclr, busy, cmd_done, cmd_err, write_count
  );

endinterface

// File: rtl/ts_pid_sweep.sv
// rtl/ts_pid_sweep.sv - lo..hi table address generator, one write per cycle, no wrap past hi
module ts_pid_sweep
  import ts_pkg::*;
#(
  parameter int PID_W = ts_pkg::PID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clr,
  input  logic [PID_W-1:0] lo,
  input  logic [PID_W-1:0] hi,
  output logic [PID_W-1:0] addr,
  output logic             wren,
  output logic             last,
  output logic [PID_W:0]   count
);

  logic [PID_W-1:0] addr_q, addr_d;
  logic [PID_W-1:0] hi_q, hi_d;
  logic             wren_q, wren_d;
  logic [PID_W:0]   count_q, count_d;

  // Ending on equality with hi (not on overflow) lets hi = all-ones stop cleanly.
  assign last = wren_q && (addr_q == hi_q);

  always_comb begin
    addr_d  = addr_q;
    hi_d    = hi_q;
    wren_d  = wren_q;
    count_d = count_q + {{PID_W{1'b0}}, wren_q};
    if (clr || start) begin
      count_d = '0;
    end
    if (start) begin
      addr_d = lo;
      hi_d   = hi;
      wren_d = 1'b1;
    end else if (wren_q) begin
      if (addr_q == hi_q) begin
        wren_d = 1'b0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      hi_q    <= '0;
      wren_q  <= 1'b0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      wren_q  <= wren_d;
      count_q <= count_d;
    end
  end

  assign addr  = addr_q;
  assign wren  = wren_q;
  assign count = count_q;

endmodule

// File: rtl/ts_pid_table_ctrl.sv
// rtl/ts_pid_table_ctrl.sv - command FSM and flush timer driving the TS filter PID pass/drop table
module ts_pid_table_ctrl
  import ts_pkg::*;
#(
  parameter int PID_W        = ts_pkg::PID_W,
  parameter int FLUSH_CYCLES = 4,
  parameter int INIT_DROP    = 1
) (
  input  logic                clk,
  input  logic                reset,
  ts_pid_table_ctrl_if.slave  bus
);

  localparam logic [PID_W-1:0] PID_MAX    = '1;
  localparam logic [PID_W-1:0] PID_ZERO   = '0;
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic             init_q, init_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic             data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_out_q, err_out_d;
  logic             aclr_q, aclr_d;

  logic             sw_start, sw_clr, sw_wren, sw_last;
  logic [PID_W-1:0] sw_lo, sw_hi, sw_addr;
  logic [PID_W:0]   sw_count;

  ts_pid_sweep #(.PID_W(PID_W)) u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (sw_start),
    .clr   (sw_clr),
    .lo    (sw_lo),
    .hi    (sw_hi),
    .addr  (sw_addr),
    .wren  (sw_wren),
    .last  (sw_last),
    .count (sw_count)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    init_d      = init_q;
    flush_d     = flush_q;
    err_d       = err_q;
    data_d      = data_q;
    sw_start    = 1'b0;
    sw_clr      = 1'b0;
    sw_lo       = bus.cmd_pid_lo;
    sw_hi       = bus.cmd_pid_lo;

    case (state_q)
      ST_INIT_SWEEP: begin
        // Sweep is idle only in the first cycle after reset; it ends on the same edge we leave.
        if (!sw_wren) begin
          sw_start = 1'b1;
          sw_lo    = PID_ZERO;
          sw_hi    = PID_MAX;
          data_d   = 1'(INIT_DROP);
        end else if (sw_last) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      ST_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          sw_clr  = 1'b1;
          flush_d = bus.cmd_flush;
          err_d   = 1'b0;
          case (bus.cmd_op)
            OP_PASS_PID, OP_DROP_PID: begin
              sw_start = 1'b1;
              data_d   = (bus.cmd_op == OP_PASS_PID) ? TBL_PASS : TBL_DROP;
              state_d  = ST_WRITE;
            end
            OP_PASS_RANGE, OP_DROP_RANGE: begin
              if (bus.cmd_pid_lo > bus.cmd_pid_hi) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                sw_start = 1'b1;
                sw_hi    = bus.cmd_pid_hi;
                data_d   = (bus.cmd_op == OP_PASS_RANGE) ? TBL_PASS : TBL_DROP;
                state_d  = ST_WRITE;
              end
            end
            OP_PASS_ALL, OP_DROP_ALL: begin
              sw_start = 1'b1;
              sw_lo    = PID_ZERO;
              sw_hi    = PID_MAX;
              data_d   = (bus.cmd_op == OP_PASS_ALL) ? TBL_PASS : TBL_DROP;
              state_d  = ST_WRITE;
            end
            OP_NOP: begin
              if (bus.cmd_flush) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
              end else begin
                state_d = ST_DONE;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (sw_last) begin
          if (flush_q) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          if (init_q) begin
            state_d = ST_IDLE;
            init_d  = 1'b0;
            sw_clr  = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    err_out_d = (state_d == ST_DONE) && err_d;
    aclr_d    = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT_SWEEP;
      flush_cnt_q <= 4'd0;
      init_q      <= 1'b1;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      aclr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      init_q      <= init_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
      aclr_q      <= aclr_d;
    end
  end

  assign bus.cmd_ready        = ready_q;
  assign bus.busy             = busy_q;
  assign bus.cmd_done         = done_q;
  assign bus.cmd_err          = err_out_q;
  assign bus.filter_aclr      = aclr_q;
  assign bus.table_wr_address = sw_addr;
  assign bus.table_wren       = sw_wren;
  assign bus.table_data       = data_q;
  assign bus.write_count      = sw_count;

endmodule

// File: doc/ts_pid_table_ctrl.md
Name: ts_pid_table_ctrl

Overview:
- Host-facing controller that configures the 8192-entry x 1-bit PID pass/drop table of the TS PID filter.
- Sits between the USB command decoder and the filter's `table_wr_address` / `table_data` / `table_wren` port.
- Executes single-PID, PID-range and whole-table commands as one table write per clock.
- Can pulse the filter's `fifo_aclr` so the filter resynchronises after a table change.
- Table encoding: 0 = PID passed, 1 = PID dropped.

Parameters:
- `PID_W`, 13, PID/table address width (table depth 2^PID_W).
- `FLUSH_CYCLES`, 4, length of the `filter_aclr` pulse in cycles (1..15).
- `INIT_DROP`, 1, value written to every entry by the post-reset sweep (1 = drop all).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode: 0 NOP, 1 PASS_PID, 2 DROP_PID, 3 PASS_RANGE, 4 DROP_RANGE, 5 PASS_ALL, 6 DROP_ALL, 7 reserved.
- `cmd_pid_lo`  in  PID_W  single PID, or range start.
- `cmd_pid_hi`  in  PID_W  range end, inclusive; ignored for non-range ops.
- `cmd_flush`  in  1  pulse `filter_aclr` after the writes complete.
- `table_wr_address`  out  PID_W  table write address.
- `table_data`  out  1  table write data.
- `table_wren`  out  1  table write enable.
- `filter_aclr`  out  1  filter FIFO clear/resync.
- `busy`  out  1  any non-IDLE state.
- `cmd_done`  out  1  one-cycle pulse when a command completes.
- `cmd_err`  out  1  one-cycle pulse, coincident with `cmd_done`, for a rejected command.
- `write_count`  out  PID_W+1  number of entries written by the last command (range 0..8192).

Behaviour:
- **Reset.** All outputs are 0 except `busy` = 1. State = INIT_SWEEP, address counter = 0. Reset asserted in any state (including mid-sweep or mid-flush) aborts the operation and restarts INIT_SWEEP on the next cycle; no partial `cmd_done`.
- **States.** INIT_SWEEP, IDLE, WRITE, FLUSH, DONE.
- **INIT_SWEEP.**
  - Writes `INIT_DROP` to addresses 0..8191, one per cycle (8192 `table_wren` cycles).
  - Then goes to FLUSH for `FLUSH_CYCLES`, then IDLE.
  - No `cmd_done` is issued.
- **IDLE.**
  - `cmd_ready` = 1 and `busy` = 0.
  - A command is accepted on the edge where `cmd_valid` && `cmd_ready`; opcode, PIDs and flush flag are latched.
  - `cmd_ready` falls the following cycle.
- **Decode of the accepted command:**
  - PASS_PID/DROP_PID: lo = hi = `cmd_pid_lo`.
  - PASS_*: data = 0; DROP_*: data = 1.
  - *_ALL: lo = 0, hi = 2^PID_W − 1.
  - NOP: zero writes → DONE, or FLUSH first if `cmd_flush`.
  - Op 7, or a range op with lo > hi: no writes, `write_count` = 0, go to DONE with `cmd_err`.
- **WRITE.**
  - Accept at edge N gives the first `table_wren` = 1 in cycle N+1, address = lo.
  - Address increments each cycle; the last write is at address hi.
  - `table_wren` is high for exactly hi − lo + 1 consecutive cycles, with `table_data` constant.
  - The address counter must not wrap: termination is by comparison with hi before increment, so hi = 8191 terminates cleanly.
  - `write_count` counts the writes. It is cleared on accept and is stable when `cmd_done` is asserted.
- **FLUSH** (entered after WRITE if the latched `cmd_flush` = 1). `filter_aclr` = 1 for exactly `FLUSH_CYCLES` cycles, `table_wren` = 0, then DONE. `filter_aclr` is always 0 outside FLUSH, so the filter sees exactly one rising edge per flush.
- **DONE.** `cmd_done` = 1 for one cycle (plus `cmd_err` if rejected). `busy` = 1. Next cycle IDLE, with `cmd_ready` = 1.
- **Latency.** Single PID without flush: accept at N, write at N+1, `cmd_done` at N+2, `cmd_ready` at N+3.
- **Ignored inputs.** Command inputs changing while busy are ignored. `cmd_valid` held high in IDLE starts the next command immediately (back-to-back).
- **Output registration.** All outputs are registered; `table_wren`, `table_wr_address` and `table_data` change together.

Decomposition:
- Shared package `ts_pkg`:
  - opcode localparams (OP_NOP..OP_RSVD);
  - PID_W = 13;
  - table polarity constants TBL_PASS = 0, TBL_DROP = 1.
- One natural sub-module, `ts_pid_sweep`:
  - range address generator with lo/hi/start inputs;
  - addr/wren/last outputs;
  - count output.
- The FSM and flush timer stay in the top level.

Test Plan:
- **Post-reset sweep.** Release reset → exactly 8192 `table_wren` cycles, addresses 0..8191, `table_data` = 1. Then `filter_aclr` is high for 4 cycles and `cmd_ready` = 1. No `cmd_done`.
- **Single PID.** PASS_PID `cmd_pid_lo` = 0x100, flush = 0, accepted at cycle N → one write at N+1 (addr 0x100, data 0). `cmd_done` at N+2, `write_count` = 1, `cmd_ready` at N+3.
- **Range with flush.** DROP_RANGE lo = 0x1FFD, hi = 0x1FFF, flush = 1 → 3 writes (0x1FFD..0x1FFF, data 1), no wrap to 0. Then 4 `filter_aclr` cycles, then `cmd_done`, `write_count` = 3.
- **Rejected commands.** Op 7, then PASS_RANGE lo = 0x20, hi = 0x10 → no `table_wren` for either. Each gives a `cmd_done` + `cmd_err` pulse, with `write_count` = 0.
- **Full-table op with ignored traffic.** PASS_ALL with `cmd_valid` toggling and random PIDs during the sweep → 8192 writes, data 0, inputs ignored. `write_count` = 8192.
- **Reset mid-command.** Assert reset on the 50th write of a PASS_ALL → writes stop, no `cmd_done`, a fresh 8192-entry INIT_SWEEP with data 1 starts from address 0.
